// File: rtl/beam_pkg.sv
// Shared mode constants and lock-state encoding for the beam timing
// generator and the receive-side beam tracker.
package beam_pkg;

    localparam int DEF_H_TOTAL  = 1344;
    localparam int DEF_V_TOTAL  = 806;
    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_V_ACTIVE = 768;

    localparam int HW = 11;
    localparam int VW = 10;

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_e;

    function automatic logic [HW-1:0] sat_inc_h(input logic [HW-1:0] v);
        return (&v) ? v : v + HW'(1);
    endfunction

    function automatic logic [VW-1:0] sat_inc_v(input logic [VW-1:0] v);
        return (&v) ? v : v + VW'(1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Registers one active-low sync strobe and flags its falling edge.
// Both stages idle high so a released reset never fakes an edge on a high input.
module sync_edge
    import beam_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sync_n_i,
    output logic fall_o
);

    logic sync_q;
    logic sync_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= 1'b1;
            sync_prev_q <= 1'b1;
        end else begin
            sync_q      <= sync_n_i;
            sync_prev_q <= sync_q;
        end
    end

    assign fall_o = sync_prev_q & ~sync_q;

endmodule

// File: rtl/beam_tracker.sv
// Rebuilds pixel coordinates from sync/valid strobes, measures line and frame
// periods and tracks lock against the configured video mode.
module beam_tracker
    import beam_pkg::*;
#(
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          switch_line,
    input  logic          switch_frame,
    input  logic          valid,
    output logic [HW-1:0] pix_x,
    output logic [VW-1:0] pix_y,
    output logic          pix_valid,
    output logic          line_start,
    output logic          frame_start,
    output logic [HW-1:0] h_period,
    output logic [VW-1:0] v_period,
    output logic          locked,
    output logic          timing_error
);

    localparam logic [HW-1:0] H_TOTAL_C  = HW'(H_TOTAL);
    localparam logic [HW-1:0] H_ACTIVE_C = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_TOTAL_C  = VW'(V_TOTAL);
    localparam logic [VW-1:0] V_ACTIVE_C = VW'(V_ACTIVE);
    localparam logic [2:0]    LOCK_C     = 3'(LOCK_FRAMES);

    // bit 0 = line sync, bit 1 = frame sync
    logic [1:0] sync_n;
    logic [1:0] sync_fall;
    logic       hfall;
    logic       vfall;

    assign sync_n = {switch_frame, switch_line};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            sync_edge u_sync_edge (
                .clk      (clk),
                .rst      (rst),
                .sync_n_i (sync_n[gi]),
                .fall_o   (sync_fall[gi])
            );
        end
    endgenerate

    assign hfall = sync_fall[0];
    assign vfall = sync_fall[1];

    logic          s_valid_q;
    logic          s_valid_prev_q;
    logic          valid_fall;

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [HW-1:0] xcnt_q, xcnt_d;
    logic [VW-1:0] ycnt_q, ycnt_d;
    logic [VW-1:0] lcnt_q, lcnt_d;
    logic [HW-1:0] h_period_q, h_period_d;
    logic [VW-1:0] v_period_q, v_period_d;
    logic          h_armed_q, h_armed_d;
    logic          frame_ok_q, frame_ok_d;

    logic [HW-1:0] x_base;
    logic [VW-1:0] y_base;
    logic [VW-1:0] l_base;
    logic [HW-1:0] h_meas;
    logic          line_bad;
    logic          frame_clean;
    logic          unlock;

    logic [HW-1:0] pix_x_q;
    logic [VW-1:0] pix_y_q;
    logic          pix_valid_q;
    logic          line_start_q;
    logic          frame_start_q;
    logic          locked_q;
    logic          timing_error_q;

    lock_state_e   state_q, state_d;
    logic [2:0]    good_q, good_d;

    assign valid_fall = s_valid_prev_q & ~s_valid_q;

    // A line is judged at the hsync fall that ends it, and only once the
    // previous fall has given a trustworthy starting point.
    assign h_meas      = sat_inc_h(hcnt_q);
    assign line_bad    = hfall && h_armed_q &&
                         ((h_meas != H_TOTAL_C) ||
                          ((xcnt_q != '0) && (xcnt_q != H_ACTIVE_C)));
    assign frame_clean = frame_ok_q && (lcnt_q == V_TOTAL_C) && (ycnt_q == V_ACTIVE_C);
    assign unlock      = (state_q == LOCKED) && (state_d == SEEK);

    always_comb begin
        hcnt_d     = hfall ? '0 : sat_inc_h(hcnt_q);

        x_base     = hfall ? '0 : xcnt_q;
        xcnt_d     = s_valid_q ? sat_inc_h(x_base) : x_base;

        y_base     = vfall ? '0 : ycnt_q;
        ycnt_d     = valid_fall ? sat_inc_v(y_base) : y_base;

        // Frame sync wins a tie: the coincident hsync becomes line 1 of the new frame.
        l_base     = vfall ? '0 : lcnt_q;
        lcnt_d     = hfall ? sat_inc_v(l_base) : l_base;

        h_period_d = (hfall && h_armed_q) ? h_meas : h_period_q;
        v_period_d = vfall ? lcnt_q : v_period_q;

        h_armed_d  = h_armed_q;
        if (unlock) begin
            h_armed_d = 1'b0;
        end else if (hfall) begin
            h_armed_d = 1'b1;
        end

        frame_ok_d = (vfall ? 1'b1 : frame_ok_q) & ~line_bad;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        unique case (state_q)
            SEEK: begin
                if (vfall) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (vfall) begin
                    if (frame_clean) begin
                        good_d = good_q + 3'd1;
                        if (good_q + 3'd1 == LOCK_C) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (line_bad || (vfall && !frame_clean)) begin
                    state_d = SEEK;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = SEEK;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEEK;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_valid_q      <= 1'b0;
            s_valid_prev_q <= 1'b0;
            hcnt_q         <= '0;
            xcnt_q         <= '0;
            ycnt_q         <= '0;
            lcnt_q         <= '0;
            h_period_q     <= '0;
            v_period_q     <= '0;
            h_armed_q      <= 1'b0;
            frame_ok_q     <= 1'b0;
            pix_x_q        <= '0;
            pix_y_q        <= '0;
            pix_valid_q    <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            locked_q       <= 1'b0;
            timing_error_q <= 1'b0;
        end else begin
            s_valid_q      <= valid;
            s_valid_prev_q <= s_valid_q;
            hcnt_q         <= hcnt_d;
            xcnt_q         <= xcnt_d;
            ycnt_q         <= ycnt_d;
            lcnt_q         <= lcnt_d;
            h_period_q     <= h_period_d;
            v_period_q     <= v_period_d;
            h_armed_q      <= h_armed_d;
            frame_ok_q     <= frame_ok_d;
            pix_x_q        <= x_base;
            pix_y_q        <= y_base;
            pix_valid_q    <= s_valid_q;
            line_start_q   <= hfall;
            frame_start_q  <= vfall;
            locked_q       <= (state_d == LOCKED);
            timing_error_q <= unlock;
        end
    end

    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign pix_valid    = pix_valid_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign h_period     = h_period_q;
    assign v_period     = v_period_q;
    assign locked       = locked_q;
    assign timing_error = timing_error_q;

endmodule

// File: tb/tb_beam_tracker.sv
// Directed bench for beam_tracker driven by a small in-bench raster source
// (24x10 clocks/lines, 16x6 active) so whole frames stay short.
module tb_beam_tracker;

    localparam int HT = 24;
    localparam int VT = 10;
    localparam int HA = 16;
    localparam int VA = 6;
    localparam int LF = 2;
    localparam int HS_BEG   = 18;
    localparam int HS_LEN   = 3;
    localparam int VS_LINE  = 7;
    localparam int VS_LINES = 2;
    localparam int FRAME    = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        switch_line = 1'b1;
    logic        switch_frame = 1'b1;
    logic        valid = 1'b0;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        pix_valid;
    logic        line_start;
    logic        frame_start;
    logic [10:0] h_period;
    logic [9:0]  v_period;
    logic        locked;
    logic        timing_error;

    beam_tracker #(
        .H_TOTAL     (HT),
        .V_TOTAL     (VT),
        .H_ACTIVE    (HA),
        .V_ACTIVE    (VA),
        .LOCK_FRAMES (LF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .switch_line  (switch_line),
        .switch_frame (switch_frame),
        .valid        (valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_valid    (pix_valid),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .h_period     (h_period),
        .v_period     (v_period),
        .locked       (locked),
        .timing_error (timing_error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("check %s: %0d ok", tag, got);
        end
    endtask

    // source state
    int gx = 0, gy = 0, cyc = 0;
    bit gen_en = 1'b0;
    int vs_off = HS_BEG;
    int stretch_line = -1;
    int drop_line = -1;
    bit prev_hs = 1'b1, prev_vs = 1'b1;
    int hfall_q[$];
    int vfall_q[$];
    bit watch = 1'b0;
    int mark_cyc = -1;
    bit s1_v = 1'b0, s2_v = 1'b0;
    int s1_x = 0, s1_y = 0, s2_x = 0, s2_y = 0;

    // observation state
    int cnt_ls = 0, cnt_fs = 0, cnt_pv = 0;
    int te_cnt = 0, te_cyc = -1, lock_rise = -1;
    bit locked_prev = 1'b0;
    bit stream_on = 1'b0;
    int stream_err = 0;
    bit track_x = 1'b0;
    int max_x = -1, max_y = -1;
    bit want_first = 1'b0;
    int first_x = -1, first_y = -1;

    task automatic step();
        int  hlen, p, vsp;
        bit  v, hs, vs;
        @(negedge clk);
        cyc++;
        if (line_start)  cnt_ls++;
        if (frame_start) begin cnt_fs++; want_first = 1'b1; end
        if (pix_valid) begin
            cnt_pv++;
            if (track_x && int'(pix_x) > max_x) max_x = int'(pix_x);
            if (track_x && int'(pix_y) > max_y) max_y = int'(pix_y);
            if (want_first) begin
                first_x = int'(pix_x);
                first_y = int'(pix_y);
                want_first = 1'b0;
            end
        end
        if (stream_on) begin
            if (pix_valid != s2_v) stream_err++;
            else if (pix_valid && (int'(pix_x) != s2_x || int'(pix_y) != s2_y)) stream_err++;
        end
        if (timing_error) begin te_cnt++; te_cyc = cyc; track_x = 1'b0; end
        if (locked && !locked_prev) lock_rise = cyc;
        locked_prev = locked;
        s2_v = s1_v; s2_x = s1_x; s2_y = s1_y;

        if (!gen_en) begin
            switch_line = 1'b1; switch_frame = 1'b1; valid = 1'b0; s1_v = 1'b0;
        end else begin
            hlen = HT + ((gy == stretch_line) ? 1 : 0);
            v = (gx < HA) && (gy < VA);
            if (v && gy == drop_line && gx == 5) begin
                v = 1'b0; drop_line = -1; watch = 1'b1; max_x = -1; track_x = 1'b1;
            end
            if (gy == stretch_line && gx == HT) begin
                stretch_line = -1; watch = 1'b1;
            end
            hs  = !(gx >= HS_BEG && gx < HS_BEG + HS_LEN);
            p   = gy * HT + gx;
            vsp = VS_LINE * HT + vs_off;
            vs  = !(p >= vsp && p < vsp + VS_LINES * HT);
            if (prev_hs && !hs) begin
                hfall_q.push_back(cyc);
                if (watch) begin mark_cyc = cyc; watch = 1'b0; end
            end
            if (prev_vs && !vs) vfall_q.push_back(cyc);
            prev_hs = hs; prev_vs = vs;
            switch_line = hs; switch_frame = vs; valid = v;
            s1_v = v; s1_x = gx; s1_y = gy;
            gx++;
            if (gx >= hlen) begin
                gx = 0;
                gy = (gy == VT - 1) ? 0 : gy + 1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_lock(input string tag, input int budget);
        int n = 0;
        while (!locked && n < budget) begin step(); n++; end
        if (!locked) check(tag, 0, 1);
    endtask

    task automatic wait_te(input string tag, input int budget);
        int n = 0;
        while (te_cnt == 0 && n < budget) begin step(); n++; end
        if (te_cnt == 0) check(tag, 0, 1);
    endtask

    function automatic int lock_exp(input int idx);
        return (idx < vfall_q.size()) ? vfall_q[idx] + 2 : -100;
    endfunction

    initial begin
        int vidx, hidx, n;

        // reset state
        run(3);
        check("rst_pix_x", int'(pix_x), 0);
        check("rst_pix_y", int'(pix_y), 0);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_line_start", int'(line_start), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_h_period", int'(h_period), 0);
        check("rst_v_period", int'(v_period), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_timing_error", int'(timing_error), 0);
        rst = 1'b1;
        gen_en = 1'b1;

        // initial acquisition with hsync/vsync falling together
        wait_lock("lock1_timeout", FRAME * 5);
        check("lock1_cycle", lock_rise, lock_exp(2));
        run(10);
        check("lock1_h_period", int'(h_period), HT);
        check("lock1_v_period", int'(v_period), VT);

        cnt_ls = 0; cnt_fs = 0; cnt_pv = 0; stream_err = 0;
        max_x = -1; max_y = -1; track_x = 1'b1; stream_on = 1'b1;
        want_first = 1'b0; first_x = -1; first_y = -1;
        run(FRAME);
        stream_on = 1'b0; track_x = 1'b0;
        check("frame_line_starts", cnt_ls, VT);
        check("frame_frame_starts", cnt_fs, 1);
        check("frame_pix_valid", cnt_pv, HA * VA);
        check("pixel_stream_errs", stream_err, 0);
        check("max_pix_x", max_x, HA - 1);
        check("max_pix_y", max_y, VA - 1);
        run(HT * 4);
        check("first_pix_x", first_x, 0);
        check("first_pix_y", first_y, 0);
        check("no_error_while_locked", te_cnt, 0);

        // stretched line
        te_cnt = 0; mark_cyc = -1; stretch_line = 2;
        wait_te("stretch_te_timeout", FRAME * 2);
        vidx = vfall_q.size();
        check("stretch_te_cycle", te_cyc, mark_cyc + 2);
        check("stretch_h_period", int'(h_period), HT + 1);
        run(1);
        check("stretch_te_width", int'(timing_error), 0);
        check("stretch_unlocked", int'(locked), 0);
        run_to(mark_cyc + HT + 4);
        check("stretch_first_hsync_unmeasured", int'(h_period), HT + 1);
        run_to(mark_cyc + 2 * HT + 4);
        check("stretch_remeasured", int'(h_period), HT);
        wait_lock("stretch_relock_timeout", FRAME * 5);
        check("stretch_relock_cycle", lock_rise, lock_exp(vidx + 2));
        check("stretch_te_count", te_cnt, 1);

        // dropped valid cycle
        te_cnt = 0; mark_cyc = -1; drop_line = 3;
        wait_te("drop_te_timeout", FRAME * 2);
        vidx = vfall_q.size();
        check("drop_te_cycle", te_cyc, mark_cyc + 2);
        check("drop_peak_pix_x", max_x, HA - 2);
        check("drop_h_period", int'(h_period), HT);
        run(1);
        check("drop_unlocked", int'(locked), 0);
        wait_lock("drop_relock_timeout", FRAME * 5);
        check("drop_relock_cycle", lock_rise, lock_exp(vidx + 2));

        // asynchronous reset mid-frame, then vsync no longer coincident with hsync
        n = 0;
        while (!(gy == 3 && gx == 5) && n < FRAME * 2) begin step(); n++; end
        check("pre_rst_locked", int'(locked), 1);
        check("pre_rst_pix_valid", int'(pix_valid), 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_locked", int'(locked), 0);
        check("async_rst_pix_valid", int'(pix_valid), 0);
        check("async_rst_pix_x", int'(pix_x), 0);
        check("async_rst_pix_y", int'(pix_y), 0);
        check("async_rst_h_period", int'(h_period), 0);
        check("async_rst_v_period", int'(v_period), 0);
        vs_off = 5;
        te_cnt = 0;
        run(3);
        rst = 1'b1;
        hidx = hfall_q.size();
        n = 0;
        while (hfall_q.size() <= hidx && n < HT * 2) begin step(); n++; end
        if (hfall_q.size() > hidx) begin
            run_to(hfall_q[hidx] + 4);
            check("post_rst_h_period", int'(h_period), 0);
        end else begin
            check("post_rst_hsync_timeout", 0, 1);
        end
        vidx = vfall_q.size();
        wait_lock("post_rst_lock_timeout", FRAME * 5);
        check("post_rst_lock_cycle", lock_rise, lock_exp(vidx + 2));
        run(10);
        check("offset_vsync_v_period", int'(v_period), VT);
        check("offset_vsync_h_period", int'(h_period), HT);
        check("post_rst_no_error", te_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
